// File: rtl/counter_period_monitor.sv
// counter_period_monitor
//   Consumes samples of a wrapping counter (0..WRAP_VAL, then back to 0) and
//   checks that each enabled sample is a legal step from the previous one. It
//   measures the clock-cycle period between consecutive wrap samples and
//   queues each period in a small FIFO that drains over a valid/ready stream.
//
// Build option:
//   COUNTER_MON_DROP_CNT_EN - when defined, io_drop_count counts records
//                             lost to a full FIFO (saturating at 255). When
//                             undefined, io_drop_count is tied to 0 and no
//                             counter is built.
//
// Ports:
//   clock         in  1       rising-edge clock
//   reset         in  1       asynchronous active-high reset
//   io_in         in  WIDTH   counter sample
//   io_en         in  1       io_in is a valid sample this cycle
//   io_out_valid  out 1       period record available
//   io_out_ready  in  1       sink accepts the record
//   io_out_bits   out PCNT_W  period in clock cycles (head of FIFO)
//   io_err        out 1       sticky sequence-error flag
//   io_drop_count out 8       dropped-record count (0 unless option defined)
module counter_period_monitor #(
    parameter int WIDTH    = 8,
    parameter int WRAP_VAL = 10,
    parameter int PCNT_W   = 16,
    parameter int DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  io_in,
    input  logic              io_en,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [PCNT_W-1:0] io_out_bits,
    output logic              io_err,
    output logic [7:0]        io_drop_count
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [WIDTH-1:0]  WRAP     = WIDTH'(WRAP_VAL);
    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;
    localparam logic [AW:0]       CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Sequence checker and period counter
    // ------------------------------------------------------------------
    state_t              state_reg;
    logic [WIDTH-1:0]    prev_reg;
    logic [PCNT_W-1:0]   pcnt_reg;
    logic                err_reg;
    logic                push_req_reg;   // record waiting to enter the FIFO
    logic [PCNT_W-1:0]   push_data_reg;

    logic                is_wrap;
    logic                is_step;
    logic [PCNT_W-1:0]   pcnt_inc;

    assign is_wrap  = (prev_reg == WRAP) && (io_in == '0);
    assign is_step  = (prev_reg < WRAP) && (io_in == prev_reg + WIDTH'(1));
    assign pcnt_inc = (pcnt_reg == PCNT_MAX) ? PCNT_MAX : pcnt_reg + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            prev_reg      <= '0;
            pcnt_reg      <= '0;
            err_reg       <= 1'b0;
            push_req_reg  <= 1'b0;
            push_data_reg <= '0;
        end else begin
            push_req_reg <= 1'b0;
            // The period counts clock cycles, not samples.
            if (state_reg == ST_RUN) begin
                pcnt_reg <= pcnt_inc;
            end
            if (io_en) begin
                prev_reg <= io_in;
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (is_wrap) begin
                            pcnt_reg  <= '0;
                            state_reg <= ST_RUN;
                        end else if (!is_step) begin
                            err_reg <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (is_wrap) begin
                            // Counting the wrap cycle itself makes the record
                            // pcnt+1.
                            push_req_reg  <= 1'b1;
                            push_data_reg <= pcnt_inc;
                            pcnt_reg      <= '0;
                        end else if (!is_step) begin
                            err_reg   <= 1'b1;
                            pcnt_reg  <= '0;
                            state_reg <= ST_SYNC;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic [PCNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     rd_ptr_next;
    logic [AW:0]       count_reg;
    logic [AW:0]       count_next;
    logic              valid_reg;
    logic [PCNT_W-1:0] out_bits_reg;

    logic              pop;
    logic              full;
    logic              push_ok;

    assign pop         = valid_reg && io_out_ready;
    assign full        = (count_reg == CNT_FULL);
    assign push_ok     = push_req_reg && (!full || pop);
    assign rd_ptr_next = rd_ptr_reg + 1'b1;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; the pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            out_bits_reg <= '0;
        end else begin
            count_reg <= count_next;
            valid_reg <= (count_next != '0);
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            // Head register: load the pushed record when it becomes the head
            // (FIFO empty, or its single entry is leaving); otherwise fetch
            // the next stored entry on a pop. With nothing left, the last
            // value is held.
            if (push_ok && ((count_reg == '0) || (pop && count_reg == CNT_ONE))) begin
                out_bits_reg <= push_data_reg;
            end else if (pop && (count_reg > CNT_ONE)) begin
                out_bits_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign io_out_valid = valid_reg;
    assign io_out_bits  = out_bits_reg;
    assign io_err       = err_reg;

    // ------------------------------------------------------------------
    // Optional dropped-record counter
    // ------------------------------------------------------------------
`ifdef COUNTER_MON_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_reg;

    assign drop = push_req_reg && !push_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt_reg <= 8'd0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign io_drop_count = drop_cnt_reg;
`else
    assign io_drop_count = 8'd0;
`endif

endmodule

// File: doc/counter_period_monitor.md
# counter_period_monitor

Downstream consumer of the 8-bit wrapping counter. It samples the counter value, checks that each sample is a legal step of the count sequence, and measures the clock-cycle period between wrap events. Each measured period is pushed into a small FIFO and presented on a valid/ready output stream. It sits between the counter and any host or logging sink that consumes period records.

## Interface
- `WIDTH`, 8: counter value width.
- `WRAP_VAL`, 10: last value before the counter wraps to 0.
- `PCNT_W`, 16: period record width.
- `DEPTH`, 4: FIFO depth in records; power of 2, at least 2.

- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `io_in` in WIDTH: counter value.
- `io_en` in 1: `io_in` is a valid sample this cycle.
- `io_out_valid` out 1: record available.
- `io_out_ready` in 1: sink accepts the record.
- `io_out_bits` out PCNT_W: period in clock cycles.
- `io_err` out 1: sticky sequence-error flag.
- `io_drop_count` out 8: dropped-record count (see Configuration).

## Operation
- **Legal step:** an `io_en` sample `s` is legal versus the previous sample `p` when `s == p+1` (with `p < WRAP_VAL`), or when `p == WRAP_VAL` and `s == 0` (a wrap).
- **IDLE:** the state after reset. The first `io_en` sample loads `prev` and moves to SYNC.
- **SYNC:**
  - Each `io_en` sample is checked, and `prev` is updated.
  - A wrap sample clears `pcnt` to 0 and moves to RUN.
  - An illegal sample sets `io_err` and stays in SYNC.
- **RUN:**
  - `pcnt` increments every clock cycle, whether or not `io_en` is high, and saturates at 2^PCNT_W-1.
  - On a wrap sample, the record `pcnt+1` (saturated) is pushed and `pcnt` is cleared to 0.
  - An illegal sample sets `io_err`, discards `pcnt`, and returns to SYNC.
- **Samples outside legal range:** a sample with value greater than `WRAP_VAL` is illegal. `prev` always takes the latest sample, legal or not.
- **`io_err`:** stays set until reset.
- **FIFO:** DEPTH entries with pointers that wrap.
  - Push succeeds if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the record is dropped.
  - A pop occurs when `io_out_valid && io_out_ready`.
  - `io_out_bits` is the head entry. While the FIFO is empty, `io_out_valid` is 0 and `io_out_bits` holds its last value.

## Timing
- **Reset values:**
  - `io_out_valid` = 0, `io_out_bits` = 0, `io_err` = 0, `io_drop_count` = 0.
  - FIFO empty, state IDLE, `pcnt` = 0, `prev` = 0.
- **Output latency:** a wrap sample at edge N makes the record visible on `io_out_valid` after edge N+1. The FIFO is registered, with no bypass.
- **Handshake:**
  - The head is stable while `io_out_valid && !io_out_ready`.
  - A pop at edge N shows the next entry, or drops valid, after edge N.
- **Simultaneous push and pop on an empty FIFO:** cannot occur, because valid is 0 when empty. The push is accepted.
- **Free-running counter with `io_en`=1:** records equal `WRAP_VAL+1` (11), one per 11 cycles.
- **Reset asserted mid-operation:** all state clears immediately and asynchronously. Partial periods and FIFO contents are lost.

## Configuration
- Controlled by the macro `COUNTER_MON_DROP_CNT_EN`.
- **Defined:** `io_drop_count` increments, saturating at 255, on every dropped push. It resets to 0.
- **Undefined:** `io_drop_count` is constant 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- **Free-run:** reset, then `io_en`=1 with the counter stepping 0..10 and wrapping, `io_out_ready`=1.
  - The first record is 11, seen one cycle after the second wrap sample seen (the first wrap only enters RUN).
  - Records of 11 follow every 11 cycles, and `io_err` stays 0.
- **Enable gaps:** the counter is held for 3 cycles with `io_en`=0 in each period. Records are 14, and `io_err` stays 0.
- **Sequence error:** drive 2, 3, 7 during RUN.
  - `io_err`=1 on the cycle after the 7 is sampled.
  - No record is produced for the broken period.
  - The next record appears after two further wraps and equals 11.
- **Backpressure / full:** hold `io_out_ready`=0 for 6 wrap events.
  - `io_out_valid`=1 with head 11, and the FIFO holds 4 records.
  - With the macro defined, `io_drop_count`=2; without it, `io_drop_count`=0.
  - Raising `io_out_ready` then drains exactly 4 records.
- **Full with simultaneous pop:** with the FIFO full and `io_out_ready`=1 on the wrap cycle, the push is accepted and the drop count does not change.
- **Async reset mid-period:** pulse `reset` between clock edges mid-RUN with 2 records queued. Outputs go to 0 immediately, and after release the monitor restarts from IDLE.
